// File: rtl/ph_fifo_pkg.sv
// ph_fifo_pkg: shared tube constants and counter width helper
package ph_fifo_pkg;
  localparam logic [7:0] TUBE_RESET_DATA = 8'h41;
  localparam int R1_DEPTH = 24;
  localparam int R3_DEPTH = 2;
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) w++;
    return w;
  endfunction
endpackage

// File: rtl/ph_fifo_ram.sv
// ph_fifo_ram: DEPTH x 8 array, synchronous write, asynchronous read
module ph_fifo_ram #(
  parameter int DEPTH = 24,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ph_fifo.sv
// ph_fifo: parasite-to-host byte FIFO with registered head and status flags
module ph_fifo
  import ph_fifo_pkg::*;
#(
  parameter int DEPTH = R1_DEPTH,
  parameter int CW = cnt_width(DEPTH),
  parameter logic [7:0] RESET_DATA = TUBE_RESET_DATA
) (
  input  logic          h_phi2,
  input  logic          h_rst_b,
  input  logic          p_wr_stb,
  input  logic [7:0]    p_data,
  input  logic          h_rd_stb,
  input  logic          h_flush,
  input  logic          two_byte_mode,
  output logic [7:0]    h_data,
  output logic          h_data_available,
  output logic          p_full,
  output logic          overrun,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nx, wr_nx;
  logic [CW-1:0] cap, cnt_nx;
  logic [7:0] ram_q, head_nx;
  logic rd_ok, wr_ok;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  always_comb begin
    cap = two_byte_mode ? CW'(R3_DEPTH) : CW'(DEPTH);
    rd_ok = h_rd_stb && count != '0;
    wr_ok = p_wr_stb && (count < cap || rd_ok);
    rd_nx = rd_ok ? inc(rd_ptr) : rd_ptr;
    wr_nx = wr_ok ? inc(wr_ptr) : wr_ptr;
    cnt_nx = count + CW'(wr_ok) - CW'(rd_ok);
    // the new head may be the byte being written this very edge
    head_nx = cnt_nx == '0 ? h_data : (wr_ok && rd_nx == wr_ptr) ? p_data : ram_q;
  end
  ph_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(h_phi2),
    .we(wr_ok && h_rst_b && !h_flush),
    .waddr(wr_ptr),
    .wdata(p_data),
    .raddr(rd_nx),
    .rdata(ram_q)
  );
  always_ff @(posedge h_phi2) begin
    if (!h_rst_b) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      h_data <= RESET_DATA;
      h_data_available <= 1'b0;
      p_full <= 1'b0;
      overrun <= 1'b0;
    end else if (h_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      h_data_available <= 1'b0;
      p_full <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rd_ptr <= rd_nx;
      wr_ptr <= wr_nx;
      count <= cnt_nx;
      h_data <= head_nx;
      h_data_available <= two_byte_mode ? cnt_nx >= CW'(2) : cnt_nx != '0;
      p_full <= cnt_nx >= cap;
      overrun <= overrun | (p_wr_stb & ~wr_ok);
    end
  end
endmodule

// File: tb/tb_ph_fifo.sv
// tb_ph_fifo: directed stimulus with a read-data scoreboard for ph_fifo
module tb_ph_fifo;
  logic h_phi2 = 1'b0;
  logic h_rst_b = 1'b0;
  logic p_wr_stb = 1'b0;
  logic [7:0] p_data = '0;
  logic h_rd_stb = 1'b0;
  logic h_flush = 1'b0;
  logic two_byte_mode = 1'b0;
  logic [7:0] h_data;
  logic h_data_available, p_full, overrun;
  logic [4:0] count;
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  ph_fifo dut (
    .h_phi2(h_phi2), .h_rst_b(h_rst_b), .p_wr_stb(p_wr_stb), .p_data(p_data),
    .h_rd_stb(h_rd_stb), .h_flush(h_flush), .two_byte_mode(two_byte_mode),
    .h_data(h_data), .h_data_available(h_data_available), .p_full(p_full),
    .overrun(overrun), .count(count)
  );

  always #5 h_phi2 = ~h_phi2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // inputs change 1 time unit after the edge; acc says the write should land
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic fl, input logic acc);
    p_wr_stb = wr;
    p_data = d;
    h_rd_stb = rd;
    h_flush = fl;
    @(posedge h_phi2);
    if (fl || !h_rst_b) exp_q.delete();
    else if (acc) exp_q.push_back(d);
    #1;
    p_wr_stb = 1'b0;
    h_rd_stb = 1'b0;
    h_flush = 1'b0;
  endtask

  // the head presented before a popping edge must be the oldest accepted byte
  always @(negedge h_phi2)
    if (h_rd_stb && !h_flush && h_rst_b && exp_q.size() > 0)
      chk("read_data", {24'b0, h_data}, {24'b0, exp_q.pop_front()});

  initial begin
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    h_rst_b = 1'b1;
    chk("rst_h_data", {24'b0, h_data}, 32'h41);
    chk("rst_count", {27'b0, count}, 0);
    chk("rst_avail", {31'b0, h_data_available}, 0);
    chk("rst_full", {31'b0, p_full}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("empty_rd_h_data", {24'b0, h_data}, 32'h41);
    chk("empty_rd_count", {27'b0, count}, 0);
    chk("empty_rd_overrun", {31'b0, overrun}, 0);

    for (int i = 0; i < 24; i++) begin
      step(1, 8'(i), 0, 0, 1);
      if (i == 0) chk("first_wr_head", {24'b0, h_data}, 0);
      if (i == 22) chk("full_before_24", {31'b0, p_full}, 0);
    end
    chk("full_after_24", {31'b0, p_full}, 1);
    chk("count_24", {27'b0, count}, 24);
    chk("avail_full", {31'b0, h_data_available}, 1);
    step(1, 8'hAA, 0, 0, 0);
    chk("overrun_set", {31'b0, overrun}, 1);
    chk("count_after_drop", {27'b0, count}, 24);
    for (int i = 0; i < 24; i++) step(0, 8'h00, 1, 0, 0);
    chk("avail_drained", {31'b0, h_data_available}, 0);
    chk("count_drained", {27'b0, count}, 0);
    chk("hold_last", {24'b0, h_data}, 32'h17);
    chk("overrun_sticky", {31'b0, overrun}, 1);
    step(0, 8'h00, 0, 1, 0);
    chk("overrun_flushed", {31'b0, overrun}, 0);

    for (int i = 0; i < 20; i++) step(1, 8'(8'h20 + i), 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'(8'h80 + i), 0, 0, 1);
    chk("wrap_count10", {27'b0, count}, 10);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0, 0);
    chk("wrap_count0", {27'b0, count}, 0);
    chk("wrap_hold", {24'b0, h_data}, 32'h89);

    for (int i = 0; i < 24; i++) step(1, 8'(8'h60 + i), 0, 0, 1);
    step(1, 8'h55, 1, 0, 1);
    chk("simul_count", {27'b0, count}, 24);
    chk("simul_overrun", {31'b0, overrun}, 0);
    chk("simul_full", {31'b0, p_full}, 1);
    chk("simul_head", {24'b0, h_data}, 32'h61);
    for (int i = 0; i < 24; i++) step(0, 8'h00, 1, 0, 0);
    chk("simul_last", {24'b0, h_data}, 32'h55);
    chk("simul_count0", {27'b0, count}, 0);

    two_byte_mode = 1'b1;
    step(1, 8'h12, 0, 0, 1);
    chk("tb_avail1", {31'b0, h_data_available}, 0);
    chk("tb_full1", {31'b0, p_full}, 0);
    step(1, 8'h34, 0, 0, 1);
    chk("tb_avail2", {31'b0, h_data_available}, 1);
    chk("tb_full2", {31'b0, p_full}, 1);
    step(1, 8'h56, 0, 0, 0);
    chk("tb_overrun", {31'b0, overrun}, 1);
    chk("tb_count", {27'b0, count}, 2);
    step(0, 8'h00, 1, 0, 0);
    chk("tb_avail_one_left", {31'b0, h_data_available}, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("tb_hold", {24'b0, h_data}, 32'h34);
    chk("tb_count0", {27'b0, count}, 0);
    two_byte_mode = 1'b0;
    step(0, 8'h00, 0, 1, 0);

    for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 0, 0, 1);
    chk("pre_flush_count", {27'b0, count}, 5);
    step(1, 8'h99, 1, 1, 0);
    chk("flush_count", {27'b0, count}, 0);
    chk("flush_avail", {31'b0, h_data_available}, 0);
    chk("flush_full", {31'b0, p_full}, 0);
    chk("flush_overrun", {31'b0, overrun}, 0);
    chk("flush_hold", {24'b0, h_data}, 32'h90);
    step(1, 8'hA0, 0, 0, 1);
    chk("post_flush_head", {24'b0, h_data}, 32'hA0);
    chk("post_flush_count", {27'b0, count}, 1);
    step(1, 8'hA1, 0, 0, 1);
    step(1, 8'hA2, 0, 0, 1);
    h_rst_b = 1'b0;
    step(1, 8'hA3, 1, 0, 0);
    h_rst_b = 1'b1;
    chk("mid_rst_h_data", {24'b0, h_data}, 32'h41);
    chk("mid_rst_count", {27'b0, count}, 0);
    chk("mid_rst_avail", {31'b0, h_data_available}, 0);
    chk("mid_rst_full", {31'b0, p_full}, 0);
    chk("mid_rst_overrun", {31'b0, overrun}, 0);
    step(1, 8'h5A, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0);
    chk("after_rst_count", {27'b0, count}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ph_fifo.md
Name: ph_fifo

Overview:
- Parameterised parasite-to-host byte FIFO, single clock domain, clocked on the host phi2.
- Sits beside the single-byte P->H buffer as the multi-byte variant: the 24-byte register-1 path, or the 2-byte register-3 path when two-byte mode is on.
- Parasite writes and host reads arrive as one-cycle strobes, already synchronised into the h_phi2 domain by the upstream select/strobe logic.
- Produces head data, host data-available and parasite full flags, consumed by the host read mux and the interrupt/status logic.

Parameters:
- DEPTH, 24, storage entries (2..32).
- CW, 5, occupancy counter width; must satisfy 2^CW > DEPTH.
- RESET_DATA, 8'h41, value driven on h_data after reset and while never written.

Ports:
- h_phi2  in  1  sole clock, all state updates on the rising edge.
- h_rst_b  in  1  synchronous active-low reset, sampled on the h_phi2 rising edge.
- p_wr_stb  in  1  one-cycle parasite write strobe.
- p_data  in  8  parasite write data, valid with p_wr_stb.
- h_rd_stb  in  1  one-cycle host read strobe; pops the head.
- h_flush  in  1  synchronous flush (Tube register-3 clear).
- two_byte_mode  in  1  register-3 V-flag mode; static while the FIFO is non-empty.
- h_data  out  8  registered head byte.
- h_data_available  out  1  host may read.
- p_full  out  1  parasite must not write.
- overrun  out  1  sticky; a write was dropped.
- count  out  CW  current occupancy.

Behaviour:
- Reset (h_rst_b=0 at an edge): rd_ptr=wr_ptr=0, count=0, h_data=RESET_DATA, h_data_available=0, p_full=0, overrun=0. Reset takes effect mid-transfer and discards all contents.
- Storage: DEPTH x 8 array. Pointers wrap from DEPTH-1 to 0; a non-power-of-two DEPTH needs explicit wrap compare.
- Effective capacity: CAP = 2 when two_byte_mode=1, otherwise DEPTH.
- Write is accepted when p_wr_stb=1 and (count<CAP, or h_rd_stb pops in the same cycle).
  - Accepted: mem[wr_ptr]<=p_data, wr_ptr advances.
  - Rejected: data dropped, pointers unchanged, overrun<=1.
- Read is effective when h_rd_stb=1 and count>0: rd_ptr advances. A read with count=0 is ignored; h_data holds and no error is flagged.
- count updates:
  - write only: +1.
  - read only: -1.
  - simultaneous write and read: unchanged.
- h_data is a registered head, updated on the same edge as the pointer/count change. It equals mem[rd_ptr] of the new state.
  - Write into an empty FIFO: h_data=p_data on the next cycle, so write-to-visible latency is 1 cycle.
  - FIFO becomes empty after a read: h_data holds the last value popped.
- h_data_available (registered, derived from the next count):
  - two_byte_mode=0: 1 when count>=1.
  - two_byte_mode=1: 1 when count>=2.
- p_full (registered): 1 when next count >= CAP.
- overrun clears only on reset or h_flush.
- h_flush: pointers=0, count=0, flags=0, overrun=0; h_data holds. Flush has priority over a same-cycle write or read, and both are discarded.
- Priority: reset > flush > read/write.
- All outputs are registered. There is no combinational path from any input to any output.

Decomposition:
- Shared tube package holds:
  - TUBE_RESET_DATA = 8'h41.
  - R1_DEPTH = 24, R3_DEPTH = 2.
  - A clog2-style width helper for CW.
- Natural sub-module: ph_fifo_ram, a DEPTH x 8 storage array with a synchronous write port and an asynchronous read port, so the array can map to distributed RAM.
- Pointer, count and flag logic stays in ph_fifo.

Test Plan:
- Reset then idle: h_data=8'h41, count=0, h_data_available=0, p_full=0, overrun=0; a h_rd_stb while empty leaves h_data=8'h41 and count=0.
- DEPTH=24, write 0x00..0x17: p_full rises on the cycle after the 24th write; a 25th write of 0xAA is dropped and overrun=1; 24 reads return 0x00..0x17 in order; h_data_available falls after the last read; h_data holds 0x17.
- Wrap-around: write 20, read 20, write 10 (0x80..0x89), read 10 -> 0x80..0x89 in order, count returns to 0.
- Full FIFO with simultaneous p_wr_stb(0x55) and h_rd_stb: head pops, 0x55 is accepted, count stays 24, overrun stays 0; 0x55 is read last.
- two_byte_mode=1: one write (0x12) -> h_data_available=0, p_full=0; second write (0x34) -> h_data_available=1, p_full=1; third write dropped and overrun=1; reads return 0x12 then 0x34.
- h_flush with count=5 and a same-cycle write: count=0, flags=0, overrun=0, written byte discarded; h_rst_b low mid-stream -> all reset values on the next cycle.
